// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped IO port block: word offsets, port count
// and address-select helpers.
package io_pkg;

  localparam int IO_NPORTS   = 4;
  localparam int IO_SEL_BIT  = 7;
  localparam int IO_STATUS_W = 4;
  localparam int IO_MASK_W   = 4;

  // Word offsets taken from addr[6:2]
  localparam logic [4:0] OFF_OUT0   = 5'h00;
  localparam logic [4:0] OFF_OUT1   = 5'h01;
  localparam logic [4:0] OFF_OUT2   = 5'h02;
  localparam logic [4:0] OFF_OUT3   = 5'h03;
  localparam logic [4:0] OFF_IN0    = 5'h10;
  localparam logic [4:0] OFF_IN1    = 5'h11;
  localparam logic [4:0] OFF_IN2    = 5'h12;
  localparam logic [4:0] OFF_IN3    = 5'h13;
  localparam logic [4:0] OFF_STATUS = 5'h14;
  localparam logic [4:0] OFF_MASK   = 5'h15;

  function automatic logic io_selected(input logic [31:0] a);
    return (a[31:IO_SEL_BIT+1] == 24'h000000) && a[IO_SEL_BIT];
  endfunction

  // Byte lanes are ignored; every access is a full word.
  function automatic logic [4:0] io_word_off(input logic [31:0] a);
    return 5'((a[IO_SEL_BIT-1:0] & 7'h7C) >> 2);
  endfunction

endpackage

// File: rtl/io_sync_detect.sv
// Two-flop synchronizer for one external input port, plus a one-cycle delayed
// copy whose mismatch with the synchronized value flags a change.
module io_sync_detect (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] async_i,
  output logic [31:0] sync_o,
  output logic        change_o
);

  logic [31:0] meta_q;
  logic [31:0] sync_q;
  logic [31:0] dly_q;

  // Synchronizer chain and delayed copy
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 32'h0;
      sync_q <= 32'h0;
      dly_q  <= 32'h0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o   = sync_q;
  assign change_o = (sync_q != dly_q);

endmodule

// File: rtl/io_port_responder.sv
// CPU-facing IO responder: four output registers, four synchronized inputs,
// change-flag STATUS with read-to-clear, and a masked interrupt.
module io_port_responder
  import io_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  input  logic        read_io_enable,
  output logic [31:0] io_read_data,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  input  logic [31:0] in_port3,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] out_port3,
  output logic [3:0]  out_strobe,
  output logic        irq
);

  logic [31:0]            in_s   [IO_NPORTS];
  logic [31:0]            sync_s [IO_NPORTS];
  logic [IO_NPORTS-1:0]   change_s;
  logic [31:0]            out_q  [IO_NPORTS];
  logic [3:0]             strobe_q;
  logic [31:0]            rd_q;
  logic [IO_STATUS_W-1:0] flags_q;
  logic [IO_STATUS_W-1:0] flags_d;
  logic [IO_MASK_W-1:0]   mask_q;

  logic                 sel_s;
  logic [4:0]           off_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic [IO_NPORTS-1:0] wr_hit_s;
  logic                 wr_mask_s;
  logic [31:0]          rd_mux_s;

  assign in_s[0] = in_port0;
  assign in_s[1] = in_port1;
  assign in_s[2] = in_port2;
  assign in_s[3] = in_port3;

  for (genvar n = 0; n < IO_NPORTS; n++) begin : g_sync
    io_sync_detect u_sync (
      .clock    (clock),
      .resetn   (resetn),
      .async_i  (in_s[n]),
      .sync_o   (sync_s[n]),
      .change_o (change_s[n])
    );
  end

  assign sel_s   = io_selected(addr);
  assign off_s   = io_word_off(addr);
  assign rd_en_s = read_io_enable && sel_s;
  assign wr_en_s = write_io_enable && sel_s;

  // Address decode, read mux and flag next-state
  always_comb begin
    wr_hit_s  = 4'b0000;
    wr_mask_s = 1'b0;
    rd_mux_s  = 32'h0;
    for (int n = 0; n < IO_NPORTS; n++) begin
      wr_hit_s[n] = wr_en_s && (off_s == OFF_OUT0 + 5'(n));
    end
    wr_mask_s = wr_en_s && (off_s == OFF_MASK);
    case (off_s)
      OFF_OUT0:   rd_mux_s = out_q[0];
      OFF_OUT1:   rd_mux_s = out_q[1];
      OFF_OUT2:   rd_mux_s = out_q[2];
      OFF_OUT3:   rd_mux_s = out_q[3];
      OFF_IN0:    rd_mux_s = sync_s[0];
      OFF_IN1:    rd_mux_s = sync_s[1];
      OFF_IN2:    rd_mux_s = sync_s[2];
      OFF_IN3:    rd_mux_s = sync_s[3];
      OFF_STATUS: rd_mux_s = {28'h0, flags_q};
      OFF_MASK:   rd_mux_s = {28'h0, mask_q};
      default:    rd_mux_s = 32'h0;
    endcase
    // A change arriving on the same edge as a STATUS read survives the clear.
    if (rd_en_s && (off_s == OFF_STATUS)) begin
      flags_d = change_s;
    end else begin
      flags_d = flags_q | change_s;
    end
  end

  // Register file, strobes, load data and change flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < IO_NPORTS; n++) out_q[n] <= 32'h0;
      strobe_q <= 4'b0000;
      rd_q     <= 32'h0;
      flags_q  <= 4'b0000;
      mask_q   <= 4'b0000;
    end else begin
      for (int n = 0; n < IO_NPORTS; n++) begin
        if (wr_hit_s[n]) out_q[n] <= datain;
      end
      strobe_q <= wr_hit_s;
      if (wr_mask_s) mask_q <= datain[IO_MASK_W-1:0];
      if (rd_en_s) rd_q <= rd_mux_s;
      flags_q <= flags_d;
    end
  end

  assign out_port0    = out_q[0];
  assign out_port1    = out_q[1];
  assign out_port2    = out_q[2];
  assign out_port3    = out_q[3];
  assign out_strobe   = strobe_q;
  assign io_read_data = rd_q;
  assign irq          = |(flags_q & mask_q);

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 Port list; reset is asynchronous active-low:
  clock  in  1  single clock, rising edge
  resetn  in  1  async active-low reset
  addr  in  32  CPU byte address
  datain  in  32  CPU store data
  write_io_enable  in  1  store strobe, one cycle per store
  read_io_enable  in  1  load strobe, one cycle per load
  io_read_data  out  32  registered load data
  in_port0..in_port3  in  32 each  external inputs, asynchronous to clock
  out_port0..out_port3  out  32 each  registered outputs
  out_strobe  out  4  bit n pulses when out_portn is written
  irq  out  1  level, high while any unmasked change flag is set

Function
REQ-002 Select: addr[31:8]==0 and addr[7]==1; unselected strobes are ignored, and no state changes.
REQ-003 Map, word offsets addr[6:2]: 0x80/84/88/8C out_port0-3 (R/W); 0xC0/C4/C8/CC in_port0-3 (RO, synchronized value); 0xD0 STATUS (RO, read-to-clear); 0xD4 MASK (R/W, bits[3:0]).
REQ-004 addr[1:0] ignored; all accesses are full 32-bit words.
REQ-005 Store to out_portn: register updates at the rising edge where write_io_enable=1; out_strobe[n]=1 for exactly the following cycle.
REQ-006 Stores to RO or unmapped offsets: ignored, no strobe.
REQ-007 Load: io_read_data updates at the edge where read_io_enable=1 (valid one cycle later) and holds until the next load; unmapped offset returns 0.
REQ-008 Simultaneous read and write strobes: both performed; read returns the pre-write value.
REQ-009 Each in_portn passes a two-flop synchronizer; readable value = second flop.
REQ-010 Change flag n sets when the synchronized value differs from its one-cycle-delayed copy.
REQ-011 STATUS bits[3:0] = change flags, bits[31:4]=0; a STATUS load returns current flags, then clears them at the same edge.
REQ-012 Flag set and STATUS-read clear in the same cycle: set wins; flag stays 1.
REQ-013 irq = |(flags & MASK[3:0]); combinational from registers only.
REQ-014 Input latency: in_port change to readable value = 2 cycles; flag set = 3rd edge.
REQ-015 Strobes asserted for consecutive cycles: each cycle is an independent access; back-to-back stores produce back-to-back strobes.

Reset
REQ-016 resetn=0 asynchronously clears out_port0-3, out_strobe, io_read_data, flags, MASK, and all synchronizer flops to 0; irq=0.
REQ-017 Reset mid-access: the in-flight store or load is discarded.
REQ-018 After release, synchronizer flops holding nonzero inputs raise change flags on the 3rd edge (they differ from reset 0); this is required behaviour.
REQ-019 First access is accepted on the first rising edge after resetn deasserts.

Structure
REQ-020 Shared package io_pkg: offset constants, IO_NPORTS=4, IO_SEL_BIT=7, STATUS/MASK widths.
REQ-021 Sub-module io_sync_detect: two-flop synchronizer plus delayed copy and change pulse; one instance per in_port.
REQ-022 Decode, registers, and read mux live in io_port_responder; no latches, one clock domain after the synchronizers.

Verification
REQ-023 Reset, in_port0..3=0x22222222/0x55555555/0x88888888/0xFFFFFFFF, release -> flags 0xF at 3rd edge; STATUS load returns 0xF, next STATUS load returns 0x0.
REQ-024 Store 0x12345678 to 0x84 -> out_port1=0x12345678 next cycle, out_strobe=0b0010 for one cycle; load 0x84 returns 0x12345678.
REQ-025 Store to 0xC0 and to 0x1084 -> no register change, out_strobe stays 0; load 0x9C -> io_read_data=0.
REQ-026 MASK=0x4, in_port2 toggles to 0x88888889 -> irq=1 on 3rd edge; in_port1 change with MASK bit1=0 -> irq unaffected.
REQ-027 in_port3 change synchronized on the same cycle as a STATUS load -> bit3 remains set after the load.
REQ-028 Simultaneous load and store to 0x8C (old 0xA, new 0xB) -> io_read_data=0xA, out_port3=0xB; resetn pulse mid-store -> all outputs 0 immediately.
